// File: rtl/bird_dispatcher.sv
// Per-duck lifecycle sequencer for one round: wait, spawn, fly, then fall or escape, until the keeper reports no birds left.
// All outputs are registered; one phase timer is shared by every timed state and counts frame ticks.
module bird_dispatcher #(
   parameter int SPAWN_DELAY   = 60,
   parameter int FLIGHT_FRAMES = 300,
   parameter int FALL_FRAMES   = 45,
   parameter int ESCAPE_FRAMES = 30
) (
   input  logic       Clk,
   input  logic       Reset,
   input  logic       frame_tick,
   input  logic       start,
   input  logic       bird_hit,
   input  logic       no_birds_left,
   output logic [2:0] state,
   output logic       spawn,
   output logic       flew_away,
   output logic       bird_active,
   output logic       bird_falling,
   output logic [9:0] spawn_x,
   output logic [9:0] frames_left,
   output logic [7:0] hits
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      WAIT   = 3'd1,
      FLY    = 3'd2,
      FALL   = 3'd3,
      ESCAPE = 3'd4,
      OVER   = 3'd5
   } state_t;

   // A zero duration behaves as one frame so every timed state still expires.
   localparam logic [9:0] SPAWN_LD  = (SPAWN_DELAY   < 1) ? 10'd1 : 10'(SPAWN_DELAY);
   localparam logic [9:0] FLIGHT_LD = (FLIGHT_FRAMES < 1) ? 10'd1 : 10'(FLIGHT_FRAMES);
   localparam logic [9:0] FALL_LD   = (FALL_FRAMES   < 1) ? 10'd1 : 10'(FALL_FRAMES);
   localparam logic [9:0] ESCAPE_LD = (ESCAPE_FRAMES < 1) ? 10'd1 : 10'(ESCAPE_FRAMES);

   state_t      st;
   logic [15:0] lfsr;
   logic        lfsr_fb;
   logic        expire;

   assign lfsr_fb = lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5];
   assign expire  = frame_tick && (frames_left == 10'd1);
   assign state   = st;

   always_ff @(posedge Clk) begin
      if (Reset) begin
         st           <= IDLE;
         lfsr         <= 16'hACE1;
         spawn        <= 1'b0;
         flew_away    <= 1'b0;
         bird_active  <= 1'b0;
         bird_falling <= 1'b0;
         spawn_x      <= 10'd0;
         frames_left  <= 10'd0;
         hits         <= 8'd0;
      end else begin
         lfsr      <= {lfsr_fb, lfsr[15:1]};
         spawn     <= 1'b0;
         flew_away <= 1'b0;
         case (st)
            IDLE: begin
               if (start) begin
                  st          <= WAIT;
                  frames_left <= SPAWN_LD;
               end
            end
            WAIT: begin
               // The keeper's verdict outranks a pending spawn.
               if (no_birds_left) begin
                  st <= OVER;
               end else if (expire) begin
                  st          <= FLY;
                  spawn       <= 1'b1;
                  spawn_x     <= {1'b0, lfsr[8:0]} + 10'd64;
                  frames_left <= FLIGHT_LD;
                  bird_active <= 1'b1;
               end else if (frame_tick) begin
                  frames_left <= frames_left - 10'd1;
               end
            end
            FLY: begin
               if (bird_hit) begin
                  st           <= FALL;
                  frames_left  <= FALL_LD;
                  bird_active  <= 1'b0;
                  bird_falling <= 1'b1;
                  if (hits != 8'hFF) hits <= hits + 8'd1;
               end else if (expire) begin
                  st          <= ESCAPE;
                  frames_left <= ESCAPE_LD;
               end else if (frame_tick) begin
                  frames_left <= frames_left - 10'd1;
               end
            end
            FALL: begin
               if (expire) begin
                  bird_falling <= 1'b0;
                  if (no_birds_left) begin
                     st <= OVER;
                  end else begin
                     st          <= WAIT;
                     frames_left <= SPAWN_LD;
                  end
               end else if (frame_tick) begin
                  frames_left <= frames_left - 10'd1;
               end
            end
            ESCAPE: begin
               if (expire) begin
                  st          <= WAIT;
                  flew_away   <= 1'b1;
                  bird_active <= 1'b0;
                  frames_left <= SPAWN_LD;
               end else if (frame_tick) begin
                  frames_left <= frames_left - 10'd1;
               end
            end
            OVER: begin
               st <= OVER;
            end
            default: begin
               st           <= IDLE;
               bird_active  <= 1'b0;
               bird_falling <= 1'b0;
               frames_left  <= 10'd0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bird_dispatcher.sv
// Randomized bench for bird_dispatcher against a phase/tick-count reference model with a keeper model.
module tb_bird_dispatcher;

   localparam int SD = 2;
   localparam int FF = 3;
   localparam int LF = 2;
   localparam int EF = 2;

   logic       Clk = 1'b0;
   logic       Reset;
   logic       frame_tick;
   logic       start;
   logic       bird_hit;
   logic       no_birds_left;
   logic [2:0] state;
   logic       spawn;
   logic       flew_away;
   logic       bird_active;
   logic       bird_falling;
   logic [9:0] spawn_x;
   logic [9:0] frames_left;
   logic [7:0] hits;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;

   always #5 Clk = ~Clk;

   bird_dispatcher #(
      .SPAWN_DELAY(SD), .FLIGHT_FRAMES(FF), .FALL_FRAMES(LF), .ESCAPE_FRAMES(EF)
   ) dut (
      .Clk(Clk), .Reset(Reset), .frame_tick(frame_tick), .start(start),
      .bird_hit(bird_hit), .no_birds_left(no_birds_left), .state(state),
      .spawn(spawn), .flew_away(flew_away), .bird_active(bird_active),
      .bird_falling(bird_falling), .spawn_x(spawn_x), .frames_left(frames_left),
      .hits(hits)
   );

   // Reference model: phase number, ticks seen since phase entry, and phase duration.
   int          m_phase, m_ticks, m_dur, m_hold, m_hits, m_flews, nbl_timer;
   logic        m_spawn, m_flew;
   logic [9:0]  m_sx;
   logic [15:0] m_lfsr;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s at cycle %0d: got %0d expected %0d", tag, cyc, got, exp);
      end
   endtask

   function automatic int eff(input int p);
      return (p < 1) ? 1 : p;
   endfunction

   task automatic enter(input int ph, input int d);
      m_phase = ph;
      m_ticks = 0;
      m_dur   = eff(d);
   endtask

   task automatic model_reset();
      m_phase = 0; m_ticks = 0; m_dur = 0; m_hold = 0; m_hits = 0;
      m_spawn = 1'b0; m_flew = 1'b0; m_sx = 10'd0; m_lfsr = 16'hACE1;
   endtask

   task automatic model_edge(input logic r, input logic t, input logic s,
                             input logic h, input logic n);
      logic [15:0] bit0;
      m_spawn = 1'b0;
      m_flew  = 1'b0;
      if (r) begin
         model_reset();
         return;
      end
      case (m_phase)
         0: if (s) enter(1, SD);
         1: begin
            if (n) begin
               m_hold  = m_dur - m_ticks;
               m_phase = 5;
            end else if (t) begin
               m_ticks++;
               if (m_ticks == m_dur) begin
                  m_spawn = 1'b1;
                  m_sx    = 10'd64 + 10'(m_lfsr % 512);
                  enter(2, FF);
               end
            end
         end
         2: begin
            if (h) begin
               m_hits = (m_hits < 255) ? m_hits + 1 : 255;
               enter(3, LF);
            end else if (t) begin
               m_ticks++;
               if (m_ticks == m_dur) enter(4, EF);
            end
         end
         3: if (t) begin
            m_ticks++;
            if (m_ticks == m_dur) begin
               if (n) begin
                  m_hold  = 1;
                  m_phase = 5;
               end else begin
                  enter(1, SD);
               end
            end
         end
         4: if (t) begin
            m_ticks++;
            if (m_ticks == m_dur) begin
               m_flew = 1'b1;
               enter(1, SD);
            end
         end
         default: ;
      endcase
      bit0   = (m_lfsr ^ (m_lfsr >> 2) ^ (m_lfsr >> 3) ^ (m_lfsr >> 5)) & 16'h0001;
      m_lfsr = (m_lfsr >> 1) | (bit0 << 15);
   endtask

   task automatic step();
      logic r, t, s, h, n;
      int   exp_fl;
      r = Reset; t = frame_tick; s = start; h = bird_hit; n = no_birds_left;
      @(posedge Clk);
      #1;
      model_edge(r, t, s, h, n);
      if (m_phase >= 1 && m_phase <= 4) exp_fl = m_dur - m_ticks;
      else if (m_phase == 5)            exp_fl = m_hold;
      else                              exp_fl = 0;
      check("state",        32'(state),        32'(m_phase));
      check("spawn",        32'(spawn),        32'(m_spawn));
      check("flew_away",    32'(flew_away),    32'(m_flew));
      check("bird_active",  32'(bird_active),  32'(m_phase == 2 || m_phase == 4));
      check("bird_falling", 32'(bird_falling), 32'(m_phase == 3));
      check("frames_left",  32'(frames_left),  32'(exp_fl));
      check("hits",         32'(hits),         32'(m_hits));
      check("spawn_x",      32'(spawn_x),      32'(m_sx));
      if (m_spawn) check("spawn_x_range", 32'(spawn_x >= 10'd64 && spawn_x <= 10'd575), 32'd1);
      cyc++;
      frame_tick = (cyc % 8 == 7);
   endtask

   initial begin
      model_reset();
      Reset = 1'b1; frame_tick = 1'b0; start = 1'b0; bird_hit = 1'b0; no_birds_left = 1'b0;
      m_flews = 0; nbl_timer = -1;
      for (int run = 0; run < 10; run++) begin
         int mode;
         mode  = run % 4;
         Reset = 1'b1;
         start = 1'($urandom_range(0, 1));
         bird_hit = 1'b0;
         no_birds_left = 1'b0;
         step();
         step();
         Reset = 1'b0; start = 1'b0; m_flews = 0; nbl_timer = -1;
         start = 1'b1;
         step();
         start = 1'b0;
         for (int c = 0; c < 500; c++) begin
            case (mode)
               0: bird_hit = 1'b0;
               1: bird_hit = ($urandom_range(0, 29) == 0);
               2: if ($urandom_range(0, 15) == 0) bird_hit = ~bird_hit;
               default: bird_hit = ($urandom_range(0, 9) == 0);
            endcase
            start = ($urandom_range(0, 19) == 0);
            if (mode == 3 && $urandom_range(0, 199) == 0) no_birds_left = 1'b1;
            Reset = ((run == 5 || run == 9) && c == 150);
            step();
            if (Reset) begin
               m_flews = 0; nbl_timer = -1; no_birds_left = 1'b0;
            end else begin
               if (nbl_timer > 0) begin
                  nbl_timer--;
                  if (nbl_timer == 0) no_birds_left = 1'b1;
               end
               if (m_flew) begin
                  m_flews++;
                  if (m_flews == 3) nbl_timer = 2;
               end
            end
         end
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
